// File: rtl/pal_cap_vst.sv
// PAL capture front end: turns a digitised sync/blank/pixel stream into
// Avalon-ST Video packets (one field per packet) through a small output FIFO.
module pal_cap_vst #(
    parameter int DATA_WIDTH = 10,
    parameter int IM_WIDTH   = 720,
    parameter int IM_HEIGHT  = 288,
    parameter int VSYNC_MIN  = 200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] cap_data,
    input  logic                  cap_sync_n,
    input  logic                  cap_blank_n,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    output logic                  err_overflow,
    output logic                  err_short
);

    localparam int XW = $clog2(IM_WIDTH + 1);
    localparam int YW = (IM_HEIGHT > 1) ? $clog2(IM_HEIGHT) : 1;
    localparam int SW = $clog2(VSYNC_MIN + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + 2;

    localparam logic [XW-1:0] X_END  = XW'(IM_WIDTH);
    localparam logic [XW-1:0] X_LAST = XW'(IM_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IM_HEIGHT - 1);
    localparam logic [SW-1:0] S_MAX  = SW'(VSYNC_MIN);
    localparam logic [SW-1:0] S_PRE  = SW'(VSYNC_MIN - 1);
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] C_LIM  = CW'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {SEEK, HDR, ARMED, ACTIVE, DROP, CLOSE} state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] in_data, pix_data;
    logic                  in_sync_n, in_blank_n, prev_sync_n;
    logic                  pix_valid, hs_edge, vs_pulse, sync_low;
    logic [SW-1:0]         sync_cnt;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y, y_inc;
    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [EW-1:0]         wr_word, head;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  wr, rd, full, room;
    logic                  counting, accept, last_pix, short_line;
    logic                  clr_cnt, set_short, set_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_data    <= '0;
            in_sync_n  <= 1'b1;
            in_blank_n <= 1'b0;
        end else begin
            in_data    <= cap_data;
            in_sync_n  <= cap_sync_n;
            in_blank_n <= cap_blank_n;
        end
    end

    // Second stage: sync classification, all events aligned with the pixel they accompany.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_cnt    <= '0;
            vs_pulse    <= 1'b0;
            prev_sync_n <= 1'b1;
            hs_edge     <= 1'b0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            sync_low    <= 1'b0;
        end else begin
            if (in_sync_n)
                sync_cnt <= '0;
            else if (sync_cnt != S_MAX)
                sync_cnt <= sync_cnt + 1'b1;
            vs_pulse    <= !in_sync_n && (sync_cnt == S_PRE);
            prev_sync_n <= in_sync_n;
            hs_edge     <= prev_sync_n && !in_sync_n;
            pix_valid   <= in_sync_n && in_blank_n;
            pix_data    <= in_data;
            sync_low    <= !in_sync_n;
        end
    end

    assign counting   = (state == ARMED) || (state == ACTIVE);
    assign accept     = counting && pix_valid && (x < X_END);
    assign last_pix   = (x == X_LAST) && (y == Y_LAST);
    assign short_line = counting && hs_edge && (x != '0) && (x < X_END);
    assign y_inc      = (y == Y_LAST) ? '0 : y + 1'b1;
    assign full       = (count == C_FULL);
    assign room       = (count < C_LIM);

    always_ff @(posedge clk) begin
        if (rst) state <= SEEK;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        wr         = 1'b0;
        wr_word    = '0;
        clr_cnt    = 1'b0;
        set_short  = 1'b0;
        set_ovf    = 1'b0;
        case (state)
            SEEK: if (vs_pulse) state_next = HDR;
            HDR: begin
                if (!full) begin
                    wr         = 1'b1;
                    wr_word    = {1'b1, 1'b0, {DATA_WIDTH{1'b0}}};
                    clr_cnt    = 1'b1;
                    state_next = ARMED;
                end
            end
            ARMED, ACTIVE: begin
                // Repeated broad pulses are only meaningful once pixels have started.
                if (state == ACTIVE && vs_pulse) begin
                    set_short  = 1'b1;
                    state_next = CLOSE;
                end else if (accept) begin
                    if (room) begin
                        wr         = 1'b1;
                        wr_word    = {1'b0, last_pix, pix_data};
                        state_next = last_pix ? SEEK : ACTIVE;
                    end else begin
                        set_ovf    = 1'b1;
                        state_next = DROP;
                    end
                end
            end
            DROP: if (!full) state_next = CLOSE;
            CLOSE: begin
                wr         = 1'b1;
                wr_word    = {1'b0, 1'b1, {DATA_WIDTH{1'b0}}};
                state_next = sync_low ? HDR : SEEK;
            end
            default: state_next = SEEK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x            <= '0;
            y            <= '0;
            err_short    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (clr_cnt) begin
                x <= '0;
                y <= '0;
            end else if (counting && hs_edge) begin
                x <= '0;
                if (short_line) y <= y_inc;
            end else if (accept) begin
                x <= x + 1'b1;
                if (x == X_LAST) y <= y_inc;
            end
            err_short    <= err_short | set_short | short_line;
            err_overflow <= err_overflow | set_ovf;
        end
    end

    // Pixels may fill only DEPTH-1 slots so a closing pad word always fits.
    assign rd = dout_valid && dout_ready;

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head               = mem[rd_ptr];
    assign dout_valid         = (count != '0);
    assign dout_data          = dout_valid ? head[DATA_WIDTH-1:0] : '0;
    assign dout_startofpacket = dout_valid && head[EW-1];
    assign dout_endofpacket   = dout_valid && head[EW-2];

endmodule

// File: tb/tb_pal_cap_vst.sv
// Bench for pal_cap_vst: event-level PAL field model feeds a word scoreboard
// that an independent monitor drains as the DUT hands words to the sink.
module tb_pal_cap_vst;

    localparam int DW    = 10;
    localparam int W     = 8;
    localparam int H     = 4;
    localparam int VMIN  = 12;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] cap_data;
    logic          cap_sync_n, cap_blank_n;
    logic [DW-1:0] dout_data;
    logic          dout_valid, dout_ready;
    logic          dout_startofpacket, dout_endofpacket;
    logic          err_overflow, err_short;

    always #5 clk = ~clk;

    pal_cap_vst #(
        .DATA_WIDTH(DW), .IM_WIDTH(W), .IM_HEIGHT(H),
        .VSYNC_MIN(VMIN), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cap_data(cap_data), .cap_sync_n(cap_sync_n), .cap_blank_n(cap_blank_n),
        .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket),
        .err_overflow(err_overflow), .err_short(err_short)
    );

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
    } word_t;

    word_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    // Field-level model: packet open, pixels seen, position in the field.
    bit m_open, m_started, exp_short, exp_ovf;
    int m_x, m_y, m_held;
    int ready_mode;   // 0: sink always ready, 1: random stalls outside active video, 2: sink stalled

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input bit sop, input bit eop, input logic [DW-1:0] d);
        word_t w;
        w.sop = sop; w.eop = eop; w.data = d;
        exp_q.push_back(w);
        if (ready_mode == 2) m_held++;
    endtask

    task automatic model_reset();
        m_open = 0; m_started = 0; m_x = 0; m_y = 0; m_held = 0;
        exp_short = 0; exp_ovf = 0;
    endtask

    task automatic model_hsync();
        if (m_open && m_x > 0 && m_x < W) begin
            exp_short = 1;
            m_y = (m_y + 1) % H;
        end
        m_x = 0;
    endtask

    task automatic model_vsync();
        model_hsync();
        if (!m_open) begin
            push_word(1, 0, '0);
            m_open = 1; m_started = 0; m_x = 0; m_y = 0;
        end else if (m_started) begin
            push_word(0, 1, '0);
            exp_short = 1;
            push_word(1, 0, '0);
            m_started = 0; m_x = 0; m_y = 0;
        end
    endtask

    task automatic model_pixel(input logic [DW-1:0] d);
        bit eop;
        if (m_open && m_x < W) begin
            if (ready_mode == 2 && m_held >= DEPTH - 1) begin
                exp_ovf = 1;
                push_word(0, 1, '0);
                m_open = 0;
            end else begin
                eop = (m_x == W - 1) && (m_y == H - 1);
                push_word(0, eop, d);
                m_started = 1;
                m_x++;
                if (m_x == W) m_y = (m_y + 1) % H;
                if (eop) m_open = 0;
            end
        end
    endtask

    task automatic drive(input logic s, input logic b, input logic [DW-1:0] d, input bit may_stall);
        cap_sync_n  = s;
        cap_blank_n = b;
        cap_data    = d;
        if (ready_mode == 2)                   dout_ready = 1'b0;
        else if (ready_mode == 1 && may_stall) dout_ready = 1'($urandom_range(0, 1));
        else                                   dout_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, DW'($urandom), 1);
    endtask

    task automatic apply_vsync();
        model_vsync();
        for (int i = 0; i < VMIN + 6; i++) drive(0, 0, DW'($urandom), 1);
        for (int i = 0; i < 4; i++) drive(1, 0, '0, 1);
    endtask

    task automatic apply_line(input int npix, input int base, input bit rnd);
        logic [DW-1:0] d;
        model_hsync();
        for (int i = 0; i < 3; i++) drive(0, 0, '0, 1);
        for (int i = 0; i < 2; i++) drive(1, 0, '0, 1);
        for (int i = 0; i < npix; i++) begin
            if ($urandom_range(0, 3) == 0) drive(1, 0, DW'($urandom), 0);
            d = rnd ? DW'($urandom) : DW'(base + i);
            model_pixel(d);
            drive(1, 1, d, 0);
        end
        for (int i = 0; i < 3; i++) drive(1, 0, '0, 0);
    endtask

    task automatic apply_field(input int nlines, input bit rnd);
        for (int l = 0; l < nlines; l++) apply_line(W, 16 * l, rnd);
    endtask

    task automatic wait_drain(input string name);
        int n;
        ready_mode = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            idle(1);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s: %0d words still owed, required 0", name, exp_q.size());
        end
        m_held = 0;
    endtask

    task automatic check_flags(input string name);
        idle(4);
        check({name, "_short"}, 32'(err_short), 32'(exp_short));
        check({name, "_ovf"}, 32'(err_overflow), 32'(exp_ovf));
    endtask

    task automatic do_reset(input string name, input int cycles, input bit toggle);
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        for (int i = 0; i < cycles; i++) drive(toggle ? 1'(i) : 1'b1, 0, DW'($urandom), 0);
        check({name, "_valid"}, 32'(dout_valid), 0);
        check({name, "_data"}, 32'(dout_data), 0);
        check({name, "_sop"}, 32'(dout_startofpacket), 0);
        check({name, "_eop"}, 32'(dout_endofpacket), 0);
        check({name, "_short"}, 32'(err_short), 0);
        check({name, "_ovf"}, 32'(err_overflow), 0);
        rst = 1'b0;
    endtask

    // Monitor: every accepted word is popped against the model; stalled heads must hold.
    initial begin
        word_t w, held;
        bit    stalled;
        stalled = 0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    check("hold_valid", 32'(dout_valid), 1);
                    check("hold_word", 32'({dout_startofpacket, dout_endofpacket, dout_data}), 32'(held));
                end
                if (dout_valid && dout_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL word: got sop=%0b eop=%0b data=0x%0h, required no word",
                                 dout_startofpacket, dout_endofpacket, dout_data);
                    end else begin
                        w = exp_q.pop_front();
                        check("word", 32'({dout_startofpacket, dout_endofpacket, dout_data}), 32'(w));
                    end
                end
                stalled = dout_valid && !dout_ready;
                held    = {dout_startofpacket, dout_endofpacket, dout_data};
            end
        end
    end

    initial begin
        int nv, nl, np;
        rst = 1'b1; cap_data = '0; cap_sync_n = 1'b1; cap_blank_n = 1'b0;
        dout_ready = 1'b0; ready_mode = 0;
        model_reset();

        do_reset("reset", 3, 1);
        idle(5);

        apply_vsync();
        apply_field(H, 0);
        wait_drain("nominal");
        check_flags("nominal");

        for (int i = 0; i < 5; i++) apply_vsync();
        apply_field(H, 1);
        wait_drain("multi_vsync");
        check_flags("multi_vsync");

        ready_mode = 1;
        apply_vsync();
        apply_field(H, 1);
        wait_drain("stall_field");
        check_flags("stall_field");

        apply_vsync();
        apply_field(2, 1);
        do_reset("mid_reset", 2, 0);
        idle(3);
        apply_vsync();
        apply_field(H, 1);
        wait_drain("after_reset");
        check_flags("after_reset");

        apply_vsync();
        apply_field(2, 0);
        apply_vsync();
        apply_field(H, 0);
        wait_drain("early_vsync");
        check_flags("early_vsync");

        do_reset("pre_short", 2, 0);
        idle(3);
        apply_vsync();
        apply_line(W, 0, 1);
        apply_line(5, 0, 1);
        apply_line(W, 0, 1);
        apply_line(W, 0, 1);
        apply_line(W, 0, 1);
        wait_drain("short_line");
        check_flags("short_line");

        do_reset("pre_ovf", 2, 0);
        idle(3);
        ready_mode = 2;
        apply_vsync();
        apply_line(W, 0, 1);
        check("ovf_held_valid", 32'(dout_valid), 1);
        check("ovf_flag_stalled", 32'(err_overflow), 32'(exp_ovf));
        wait_drain("overflow");
        apply_field(2, 1);
        apply_vsync();
        apply_field(H, 1);
        wait_drain("after_ovf");
        check_flags("after_ovf");

        for (int f = 0; f < 8; f++) begin
            ready_mode = 1;
            nv = $urandom_range(1, 2);
            nl = $urandom_range(2, H + 1);
            for (int v = 0; v < nv; v++) apply_vsync();
            for (int l = 0; l < nl; l++) begin
                np = ($urandom_range(0, 4) == 0) ? $urandom_range(1, W + 2) : W;
                apply_line(np, 0, 1);
            end
        end
        wait_drain("random");
        check_flags("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
